fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 tb/tb_fetch_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction prefetch sequencer: IDLE/FETCH/FULL control plus a DEPTH-entry {pc, word} queue.
// Define FETCH_PERF_CNT_EN to add the saturating fetch_count/stall_count outputs.
module fetch_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] PC,
  output logic [1:0]  PS,
  input  logic        redirect,
  input  logic        redirect_abs,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [63:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          armed;
  logic          push;
  logic          pop;
  logic [63:0]   q_pc   [DEPTH];
  logic [31:0]   q_word [DEPTH];

  assign mem_addr = PC;

  // armed marks that the current request has already been on the bus for a
  // full cycle, which keeps every fetch at two cycles minimum and drops acks
  // that belong to a request abandoned by reset or redirect.
  always_comb begin
    mem_req     = !reset && !redirect && (state == FETCH);
    push        = mem_req && armed && mem_ack;
    instr_valid = !reset && (count != '0);
    pop         = !redirect && instr_valid && instr_ready;
    count_next  = count + CW'(push) - CW'(pop);
    instr_out   = q_word[rd_ptr];
    instr_pc    = q_pc[rd_ptr];
    PS          = 2'b00;
    if (reset)
      PS = 2'b00;
    else if (redirect)
      PS = redirect_abs ? 2'b01 : 2'b11;
    else if (push)
      PS = 2'b10;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      armed  <= 1'b0;
    end else if (redirect) begin
      state  <= FETCH;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      armed  <= 1'b0;
    end else begin
      count <= count_next;
      armed <= mem_req && !push;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE:    state <= FETCH;
        FETCH:   if (push && (count_next == FULL_CNT)) state <= FULL;
        FULL:    if (pop) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

  // Queue storage is data only; validity is carried entirely by count.
  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr]   <= PC;
      q_word[wr_ptr] <= mem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push)
        fetch_count <= sat_inc(fetch_count);
      if (state == FULL)
        stall_count <= sat_inc(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: queued expected {pc, word} entries are
// compared by a monitor at every accepted pop; control outputs are spot-checked.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] PC;
  logic [1:0]  PS;
  logic        redirect;
  logic        redirect_abs;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [63:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] w;
  } item_t;

  item_t sb[$];
  item_t mon_e;
  int    checks = 0;
  int    errors = 0;

  fetch_sequencer #(.DEPTH(4)) dut (
    .clock       (clk),
    .reset       (reset),
    .PC          (PC),
    .PS          (PS),
    .redirect    (redirect),
    .redirect_abs(redirect_abs),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Request cycle then ack cycle; rdy lets the consumer pop during the ack cycle.
  task automatic fetch(input logic [31:0] w, input logic rdy);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("req_mem_req", 64'(mem_req), 64'd1);
    chk("req_ps", 64'(PS), 64'd0);
    chk("req_mem_addr", mem_addr, PC);
    nxt();
    mem_ack     = 1'b1;
    mem_rdata   = w;
    instr_ready = rdy;
    sb.push_back({PC, w});
    @(negedge clk);
    chk("ack_ps", 64'(PS), 64'd2);
    nxt();
    mem_ack     = 1'b0;
    instr_ready = 1'b0;
    PC          = PC + 64'd4;
  endtask

  always @(negedge clk) begin
    if (!reset && !redirect && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc 0x%0h word 0x%0h with nothing expected", instr_pc, instr_out);
      end else begin
        mon_e = sb.pop_front();
        chk("pop_pc", instr_pc, mon_e.pc);
        chk("pop_word", 64'(instr_out), 64'(mon_e.w));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    PC           = 64'd0;
    redirect     = 1'b0;
    redirect_abs = 1'b0;
    mem_ack      = 1'b0;
    mem_rdata    = 32'd0;
    instr_ready  = 1'b0;
    nxt();
    nxt();
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_ps", 64'(PS), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    nxt();

    // First fetch after reset
    reset = 1'b0;
    @(negedge clk);
    chk("idle_mem_req", 64'(mem_req), 64'd0);
    nxt();
    fetch(32'h8B02_0020, 1'b0);
    @(negedge clk);
    chk("first_valid", 64'(instr_valid), 64'd1);
    chk("first_word", 64'(instr_out), 64'h8B02_0020);
    chk("first_pc", instr_pc, 64'd0);
    nxt();

    // Fill to FULL, stray ack ignored, one pop restarts fetching
    fetch(32'h1111_0001, 1'b0);
    fetch(32'h1111_0002, 1'b0);
    fetch(32'h1111_0003, 1'b0);
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0_0001;
    @(negedge clk);
    chk("full_mem_req", 64'(mem_req), 64'd0);
    chk("full_ps_ack_ignored", 64'(PS), 64'd0);
    chk("full_valid", 64'(instr_valid), 64'd1);
    nxt();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("full2_mem_req", 64'(mem_req), 64'd0);
    nxt();
    instr_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_mem_req", 64'(mem_req), 64'd0);
    chk("full_pop_ps", 64'(PS), 64'd0);
    nxt();
    instr_ready = 1'b0;
    @(negedge clk);
    chk("refetch_mem_req", 64'(mem_req), 64'd1);
    nxt();

    // Relative redirect colliding with an ack at count=3
    redirect     = 1'b1;
    redirect_abs = 1'b0;
    mem_ack      = 1'b1;
    mem_rdata    = 32'hDEAD_BEEF;
    sb.delete();
    @(negedge clk);
    chk("redir_rel_ps", 64'(PS), 64'd3);
    chk("redir_mem_req", 64'(mem_req), 64'd0);
    nxt();
    redirect = 1'b0;
    mem_ack  = 1'b0;
    PC       = 64'h100;
    @(negedge clk);
    chk("redir_flush_valid", 64'(instr_valid), 64'd0);
    chk("redir_next_mem_req", 64'(mem_req), 64'd1);
    nxt();
    redirect     = 1'b1;
    redirect_abs = 1'b1;
    @(negedge clk);
    chk("redir_abs_ps", 64'(PS), 64'd1);
    nxt();
    redirect     = 1'b0;
    redirect_abs = 1'b0;
    PC           = 64'h200;

    // Push and pop together at DEPTH-1 across pointer wrap
    fetch(32'hA000_0000, 1'b0);
    fetch(32'hA000_0001, 1'b0);
    fetch(32'hA000_0002, 1'b0);
    fetch(32'hA000_0003, 1'b1);
    fetch(32'hA000_0004, 1'b1);
    fetch(32'hA000_0005, 1'b1);
    chk("wrap_valid", 64'(instr_valid), 64'd1);
    fetch(32'hA000_0006, 1'b0);
    @(negedge clk);
    chk("wrap_full_mem_req", 64'(mem_req), 64'd0);
    nxt();
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) nxt();
    instr_ready = 1'b0;
    @(negedge clk);
    chk("drain_valid", 64'(instr_valid), 64'd0);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    nxt();

    // Reset mid-fetch with an ack on the first reset cycle
    @(negedge clk);
    chk("pre_rst_mem_req", 64'(mem_req), 64'd1);
    nxt();
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_0002;
    @(negedge clk);
    chk("rst_ack_ps", 64'(PS), 64'd0);
    chk("rst_ack_mem_req", 64'(mem_req), 64'd0);
    nxt();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rst_hold_ps", 64'(PS), 64'd0);
    nxt();
    reset   = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_ps", 64'(PS), 64'd0);
    nxt();
    mem_ack = 1'b0;
    PC      = 64'h300;
    @(negedge clk);
    chk("post_rst_no_push", 64'(instr_valid), 64'd0);
    nxt();

    // Ten pushes with exactly three FULL cycles
    for (int i = 0; i < 4; i++) fetch(32'hC000_0000 + 32'(i), 1'b0);
    @(negedge clk);
    chk("perf_full1", 64'(mem_req), 64'd0);
    nxt();
    nxt();
    instr_ready = 1'b1;
    nxt();
    instr_ready = 1'b0;
    for (int i = 4; i < 10; i++) fetch(32'hC000_0000 + 32'(i), 1'b1);
    @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", 64'(fetch_count), 64'd10);
    chk("stall_count", 64'(stall_count), 64'd3);
`endif
    chk("perf_mem_req", 64'(mem_req), 64'd1);
    nxt();
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) nxt();
    instr_ready = 1'b0;
    @(negedge clk);
    chk("final_valid", 64'(instr_valid), 64'd0);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
